// File: rtl/mixer_sat_tree.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mixer_sat_tree                                                             |
// | Pipelined N-channel signed audio mixer: gain, adder tree, sat/avg output.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mixer_sat_tree #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 16,
  parameter int SAT_MODE = 1
) (
  input  logic                                 CLOCK_50,
  input  logic                                 resetn,
  input  logic                                 in_valid,
  input  logic [CHANNELS*WIDTH-1:0]            audio_in,
  input  logic [CHANNELS-1:0]                  mute,
  input  logic [CHANNELS*3-1:0]                atten,
  input  logic                                 clip_clear,
  output logic                                 out_valid,
  output logic [WIDTH-1:0]                     mix_out,
  output logic [WIDTH+$clog2(CHANNELS)-1:0]    mix_full,
  output logic                                 clip,
  output logic [15:0]                          clip_count
);

  localparam int LOG2C = $clog2(CHANNELS);
  localparam int SUMW  = WIDTH + LOG2C;

  localparam logic signed [SUMW-1:0] c_sat_max = {{(LOG2C+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SUMW-1:0] c_sat_min = ~c_sat_max;

  // Level 0 is the gain stage, level k holds CHANNELS>>k partial sums that fit
  // in WIDTH+k bits; each is kept sign-extended to SUMW so every add is exact.
  logic signed [SUMW-1:0] r_tree [0:LOG2C][0:CHANNELS-1];
  logic [LOG2C:0]         r_vld;

  logic signed [SUMW-1:0] w_sum;
  logic [WIDTH-1:0]       w_mix;
  logic                   w_sat_hit;
  logic                   w_hit;

  logic                   r_out_valid;
  logic [WIDTH-1:0]       r_mix_out;
  logic [SUMW-1:0]        r_mix_full;
  logic                   r_clip;
  logic [15:0]            r_clip_count;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_vld <= '0;
      for (int k = 0; k <= LOG2C; k++) begin
        for (int j = 0; j < CHANNELS; j++) begin
          r_tree[k][j] <= '0;
        end
      end
    end else begin
      r_vld <= {r_vld[LOG2C-1:0], in_valid};
      for (int i = 0; i < CHANNELS; i++) begin
        if (mute[i]) begin
          r_tree[0][i] <= '0;
        end else begin
          r_tree[0][i] <= SUMW'($signed(audio_in[i*WIDTH +: WIDTH]) >>> atten[i*3 +: 3]);
        end
      end
      for (int k = 1; k <= LOG2C; k++) begin
        for (int j = 0; j < (CHANNELS >> k); j++) begin
          r_tree[k][j] <= r_tree[k-1][2*j] + r_tree[k-1][2*j+1];
        end
      end
    end
  end

  assign w_sum = r_tree[LOG2C][0];

  generate
    if (SAT_MODE != 0) begin : g_sat
      always_comb begin
        w_mix     = w_sum[WIDTH-1:0];
        w_sat_hit = 1'b0;
        if (w_sum > c_sat_max) begin
          w_mix     = c_sat_max[WIDTH-1:0];
          w_sat_hit = 1'b1;
        end else if (w_sum < c_sat_min) begin
          w_mix     = c_sat_min[WIDTH-1:0];
          w_sat_hit = 1'b1;
        end
      end
    end else begin : g_avg
      // Dropping the low LOG2C bits is a flooring divide by CHANNELS.
      assign w_mix     = w_sum[SUMW-1:LOG2C];
      assign w_sat_hit = 1'b0;
    end
  endgenerate

  assign w_hit = r_vld[LOG2C] & w_sat_hit;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_out_valid  <= 1'b0;
      r_mix_out    <= '0;
      r_mix_full   <= '0;
      r_clip       <= 1'b0;
      r_clip_count <= '0;
    end else begin
      r_out_valid <= r_vld[LOG2C];
      r_mix_out   <= w_mix;
      r_mix_full  <= w_sum;
      // A clip event arriving with a clear is counted as the first new event.
      if (clip_clear && w_hit) begin
        r_clip       <= 1'b1;
        r_clip_count <= 16'd1;
      end else if (clip_clear) begin
        r_clip       <= 1'b0;
        r_clip_count <= 16'd0;
      end else if (w_hit) begin
        r_clip <= 1'b1;
        if (r_clip_count != 16'hFFFF) begin
          r_clip_count <= r_clip_count + 16'd1;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign mix_out    = r_mix_out;
  assign mix_full   = r_mix_full;
  assign clip       = r_clip;
  assign clip_count = r_clip_count;

endmodule
`default_nettype wire

// File: tb/tb_mixer_sat_tree.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mixer_sat_tree                                                          |
// | Directed table plus random frames against an arithmetic mixer model.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mixer_sat_tree;

  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic         clip_clear = 1'b0;
  logic [127:0] audio_in = '0;
  logic [7:0]   mute = '0;
  logic [23:0]  atten = '0;

  logic         s_out_valid, a_out_valid;
  logic [15:0]  s_mix_out, a_mix_out;
  logic [18:0]  s_mix_full, a_mix_full;
  logic         s_clip, a_clip;
  logic [15:0]  s_clip_count, a_clip_count;

  always #5 clk = ~clk;

  mixer_sat_tree #(.CHANNELS(8), .WIDTH(16), .SAT_MODE(1)) u_sat (
    .CLOCK_50(clk), .resetn(resetn), .in_valid(in_valid), .audio_in(audio_in),
    .mute(mute), .atten(atten), .clip_clear(clip_clear), .out_valid(s_out_valid),
    .mix_out(s_mix_out), .mix_full(s_mix_full), .clip(s_clip), .clip_count(s_clip_count)
  );

  mixer_sat_tree #(.CHANNELS(8), .WIDTH(16), .SAT_MODE(0)) u_avg (
    .CLOCK_50(clk), .resetn(resetn), .in_valid(in_valid), .audio_in(audio_in),
    .mute(mute), .atten(atten), .clip_clear(clip_clear), .out_valid(a_out_valid),
    .mix_out(a_mix_out), .mix_full(a_mix_full), .clip(a_clip), .clip_count(a_clip_count)
  );

  typedef struct {
    logic [127:0] a;
    logic [7:0]   m;
    logic [23:0]  at;
    bit           v;
    bit           clr;
    int           full;
    int           sat;
    int           avg;
    int           clip;
    int           cnt;
  } vec_t;

  typedef struct {
    bit v; int full; int sat; int avg; bit hit; bit clr;
    bit tab; bit t_v; int t_full; int t_sat; int t_avg; int t_clip; int t_cnt;
  } exp_t;

  vec_t tbl [20];
  exp_t q [$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   m_clip, m_cnt;

  task automatic chk(input string name, input integer act, input integer exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int floordiv(input int n, input int d);
    int r;
    r = n / d;
    if ((n % d) != 0 && n < 0) r = r - 1;
    return r;
  endfunction

  function automatic int model_sum(input logic [127:0] a, input logic [7:0] m, input logic [23:0] at);
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      int x;
      x = $signed(a[i*16 +: 16]);
      if (!m[i]) s += floordiv(x, 1 << at[i*3 +: 3]);
    end
    return s;
  endfunction

  function automatic logic [127:0] all_ch(input int v);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = v[15:0];
    return r;
  endfunction

  function automatic logic [127:0] ch0_only(input int base, input int v0);
    logic [127:0] r;
    r = all_ch(base);
    r[15:0] = v0[15:0];
    return r;
  endfunction

  function automatic vec_t rand_vec(input bit force_valid);
    vec_t r;
    r = '{default: 0};
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0:       r.a[i*16 +: 16] = 16'h7FFF;
        1:       r.a[i*16 +: 16] = 16'h8000;
        default: r.a[i*16 +: 16] = 16'($urandom);
      endcase
    end
    r.m   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
    r.at  = ($urandom_range(0, 1) == 0) ? 24'($urandom) : 24'h0;
    r.v   = force_valid || ($urandom_range(0, 3) != 0);
    r.clr = ($urandom_range(0, 19) == 0);
    return r;
  endfunction

  task automatic model_reset();
    exp_t z;
    z = '{default: 0};
    q.delete();
    repeat (LAT - 1) q.push_back(z);
    m_clip = 0;
    m_cnt  = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sat_valid"}, s_out_valid, 0);
    chk({tag, "_sat_mix"},   s_mix_out, 0);
    chk({tag, "_sat_full"},  s_mix_full, 0);
    chk({tag, "_sat_clip"},  s_clip, 0);
    chk({tag, "_sat_cnt"},   s_clip_count, 0);
    chk({tag, "_avg_valid"}, a_out_valid, 0);
    chk({tag, "_avg_mix"},   a_mix_out, 0);
    chk({tag, "_avg_full"},  a_mix_full, 0);
    chk({tag, "_avg_clip"},  a_clip, 0);
    chk({tag, "_avg_cnt"},   a_clip_count, 0);
  endtask

  // Present one frame; the queue head is the frame whose result lands on this edge.
  task automatic step(input vec_t tv, input bit tab);
    exp_t e, o;
    int   f;
    f = model_sum(tv.a, tv.m, tv.at);
    e = '{default: 0};
    e.v    = tv.v;
    e.full = f;
    e.sat  = (f > 32767) ? 32767 : ((f < -32768) ? -32768 : f);
    e.hit  = (e.sat != f);
    e.avg  = floordiv(f, 8);
    e.clr  = tv.clr;
    e.tab  = tab;
    e.t_v = tv.v; e.t_full = tv.full; e.t_sat = tv.sat;
    e.t_avg = tv.avg; e.t_clip = tv.clip; e.t_cnt = tv.cnt;
    q.push_back(e);
    o = q.pop_front();

    audio_in   = tv.a;
    mute       = tv.m;
    atten      = tv.at;
    in_valid   = tv.v;
    clip_clear = o.clr;
    @(posedge clk);
    #1;

    if (o.v && o.hit && o.clr) begin
      m_clip = 1; m_cnt = 1;
    end else if (o.clr) begin
      m_clip = 0; m_cnt = 0;
    end else if (o.v && o.hit) begin
      m_clip = 1;
      if (m_cnt < 65535) m_cnt++;
    end

    chk("sat_valid", s_out_valid, o.v);
    chk("sat_full",  $signed(s_mix_full), o.full);
    chk("sat_mix",   $signed(s_mix_out), o.sat);
    chk("sat_clip",  s_clip, m_clip);
    chk("sat_cnt",   s_clip_count, m_cnt);
    chk("avg_valid", a_out_valid, o.v);
    chk("avg_full",  $signed(a_mix_full), o.full);
    chk("avg_mix",   $signed(a_mix_out), o.avg);
    chk("avg_clip",  a_clip, 0);
    chk("avg_cnt",   a_clip_count, 0);
    if (o.tab) begin
      chk("tab_valid", s_out_valid, o.t_v);
      chk("tab_full",  $signed(s_mix_full), o.t_full);
      chk("tab_sat",   $signed(s_mix_out), o.t_sat);
      chk("tab_avg",   $signed(a_mix_out), o.t_avg);
      chk("tab_clip",  s_clip, o.t_clip);
      chk("tab_cnt",   s_clip_count, o.t_cnt);
    end
  endtask

  initial begin
    vec_t zv;
    zv = '{default: 0};

    //          audio                   mute   atten  v  clr full     sat     avg     clip cnt
    tbl[0]  = '{all_ch(1000),           8'h00, 24'h0, 1, 0, 8000,    8000,   1000,   0, 0};
    tbl[1]  = '{all_ch(32767),          8'h00, 24'h0, 1, 0, 262136,  32767,  32767,  1, 1};
    tbl[2]  = '{all_ch(32767),          8'h00, 24'h0, 1, 0, 262136,  32767,  32767,  1, 2};
    tbl[3]  = '{all_ch(32767),          8'h00, 24'h0, 1, 0, 262136,  32767,  32767,  1, 3};
    tbl[4]  = '{all_ch(32767),          8'h00, 24'h0, 1, 0, 262136,  32767,  32767,  1, 4};
    tbl[5]  = '{all_ch(-32768),         8'h00, 24'h0, 1, 0, -262144, -32768, -32768, 1, 5};
    tbl[6]  = '{all_ch(-32768),         8'h00, 24'h0, 1, 1, -262144, -32768, -32768, 1, 1};
    tbl[7]  = '{all_ch(0),              8'h00, 24'h0, 1, 1, 0,       0,      0,      0, 0};
    tbl[8]  = '{ch0_only(77, -100),     8'hFE, 24'h2, 1, 0, -25,     -25,    -4,     0, 0};
    tbl[9]  = '{ch0_only(77, -3),       8'hFE, 24'h1, 1, 0, -2,      -2,     -1,     0, 0};
    tbl[10] = '{ch0_only(77, -3),       8'hFF, 24'h1, 1, 0, 0,       0,      0,      0, 0};
    tbl[11] = '{all_ch(1),              8'h00, 24'h0, 1, 0, 8,       8,      1,      0, 0};
    tbl[12] = '{all_ch(2),              8'h00, 24'h0, 1, 0, 16,      16,     2,      0, 0};
    tbl[13] = '{all_ch(3),              8'h00, 24'h0, 0, 0, 24,      24,     3,      0, 0};
    tbl[14] = '{all_ch(4),              8'h00, 24'h0, 1, 0, 32,      32,     4,      0, 0};
    tbl[15] = '{all_ch(5),              8'h00, 24'h0, 0, 0, 40,      40,     5,      0, 0};
    tbl[16] = '{all_ch(6),              8'h00, 24'h0, 0, 0, 48,      48,     6,      0, 0};
    tbl[17] = '{all_ch(7),              8'h00, 24'h0, 1, 0, 56,      56,     7,      0, 0};
    tbl[18] = '{all_ch(-1),             8'h00, 24'h0, 1, 0, -8,      -8,     -1,     0, 0};
    tbl[19] = '{ch0_only(0, 7),         8'h00, 24'h0, 1, 0, 7,       7,      0,      0, 0};

    // Reset held with live traffic: outputs must stay at zero.
    resetn     = 1'b0;
    in_valid   = 1'b1;
    audio_in   = {4{32'($urandom)}};
    mute       = 8'($urandom);
    atten      = 24'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_hold");
    resetn = 1'b1;
    model_reset();

    for (int i = 0; i < 20; i++) step(tbl[i], 1'b1);
    repeat (6) step(zv, 1'b0);

    // One-cycle reset with frames in flight: none of them may surface.
    repeat (3) step(rand_vec(1'b1), 1'b0);
    resetn = 1'b0;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();

    repeat (400) step(rand_vec(1'b0), 1'b0);
    repeat (6) step(zv, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
